// File: rtl/timer_alert.sv
// timer_alert: consumer end of the countdown timer's end-of-count handshake.
// Plays a beep/burst pattern on buzzer/led while the timer's signal is high.
// It returns a one-cycle stopsignal pulse on a button acknowledge or on the auto-stop timeout.
// Optional feature macro: ALERT_ESCALATE_EN (beeps per burst grow after each burst).
module timer_alert #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned TONE_HALF    = 12500,
  parameter int unsigned BEEP_ON_MS   = 100,
  parameter int unsigned BEEP_OFF_MS  = 100,
  parameter int unsigned BURST_BEEPS  = 4,
  parameter int unsigned BURST_GAP_MS = 600,
  parameter int unsigned AUTO_STOP_MS = 30000
) (
  input  logic clk_50MHz,
  input  logic rst,
  input  logic signal,
  input  logic B_S,
  input  logic B_L,
  output logic stopsignal,
  output logic buzzer,
  output logic led,
  output logic ringing
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned AUTO_W = 32;
  localparam int unsigned BEEP_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BEEP_ON  = 3'd1,
    BEEP_OFF = 3'd2,
    GAP      = 3'd3,
    STOP     = 3'd4,
    HOLD     = 3'd5
  } state_t;

  state_t state, state_nx;

  logic sig_r, sig_p, sig_arm;
  logic bs_r, bs_p, bl_r, bl_p;
  logic sig_rise, ack;

  logic [CNT_W-1:0]  presc, ms_cnt, tone_cnt;
  logic [AUTO_W-1:0] auto_cnt, ms_ext, auto_ext;
  logic [BEEP_W-1:0] beep_cnt, beep_inc, beep_lim;
  logic tick, on_done, off_done, gap_done, auto_hit;
  logic stop_nx, led_nx, ring_nx;

  // Input registers and edge history; sig_arm blocks a rise on a level that was already high at reset.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      sig_r   <= 1'b0;
      sig_p   <= 1'b0;
      sig_arm <= 1'b0;
      bs_r    <= 1'b0;
      bs_p    <= 1'b0;
      bl_r    <= 1'b0;
      bl_p    <= 1'b0;
    end else begin
      sig_r   <= signal;
      sig_p   <= sig_r;
      sig_arm <= sig_arm | ~signal;
      bs_r    <= B_S;
      bs_p    <= bs_r;
      bl_r    <= B_L;
      bl_p    <= bl_r;
    end
  end

  // Event decode and timer terminal conditions.
  always_comb begin
    sig_rise = sig_r & ~sig_p & sig_arm;
    ack      = (bs_r & ~bs_p) | (bl_r & ~bl_p);
    tick     = (presc == CNT_W'(TICK_DIV - 1));
    ms_ext   = AUTO_W'(ms_cnt) + AUTO_W'(1);
    auto_ext = auto_cnt + AUTO_W'(1);
    on_done  = tick & (ms_ext >= AUTO_W'(BEEP_ON_MS));
    off_done = tick & (ms_ext >= AUTO_W'(BEEP_OFF_MS));
    gap_done = tick & (ms_ext >= AUTO_W'(BURST_GAP_MS));
    auto_hit = tick & (auto_ext >= AUTO_W'(AUTO_STOP_MS));
    beep_inc = beep_cnt + BEEP_W'(1);
  end

`ifdef ALERT_ESCALATE_EN
  // Burst length grows by one after every completed burst, capped at twice the base length.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      beep_lim <= BEEP_W'(BURST_BEEPS);
    end else if (state_nx == IDLE) begin
      beep_lim <= BEEP_W'(BURST_BEEPS);
    end else if (state == BEEP_ON && state_nx == GAP &&
                 beep_lim < BEEP_W'(2 * BURST_BEEPS)) begin
      beep_lim <= beep_lim + BEEP_W'(1);
    end
  end
`else
  assign beep_lim = BEEP_W'(BURST_BEEPS);
`endif

  // State and registered outputs.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state      <= IDLE;
      stopsignal <= 1'b0;
      led        <= 1'b0;
      ringing    <= 1'b0;
    end else begin
      state      <= state_nx;
      stopsignal <= stop_nx;
      led        <= led_nx;
      ringing    <= ring_nx;
    end
  end

  // Next state: ack > auto-stop > signal-low abort > pattern timer; outputs follow the next state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (sig_rise) state_nx = BEEP_ON;
      end
      BEEP_ON, BEEP_OFF, GAP: begin
        if (ack)           state_nx = STOP;
        else if (auto_hit) state_nx = STOP;
        else if (!sig_r)   state_nx = IDLE;
        else if (state == BEEP_ON) begin
          if (on_done) state_nx = (beep_inc < beep_lim) ? BEEP_OFF : GAP;
        end else if (state == BEEP_OFF) begin
          if (off_done) state_nx = BEEP_ON;
        end else begin
          if (gap_done) state_nx = BEEP_ON;
        end
      end
      STOP: state_nx = HOLD;
      HOLD: begin
        if (!sig_r) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    stop_nx = (state_nx == STOP);
    led_nx  = (state_nx == BEEP_ON);
    ring_nx = (state_nx == BEEP_ON) || (state_nx == BEEP_OFF) || (state_nx == GAP);
  end

  // Tick prescaler and per-state tick counter, both restarted on every state entry.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (state_nx != state) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + CNT_W'(1);
      if (tick && ms_cnt != CNT_MAX) ms_cnt <= ms_cnt + CNT_W'(1);
    end
  end

  // Auto-stop tick counter: cleared when leaving IDLE, counts ticks while ringing.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      auto_cnt <= '0;
    end else if (state == IDLE) begin
      if (state_nx != IDLE) auto_cnt <= '0;
    end else if (ringing && tick) begin
      auto_cnt <= auto_ext;
    end
  end

  // Beep counter within the current burst.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      beep_cnt <= '0;
    end else if (state_nx == IDLE || state_nx == STOP) begin
      beep_cnt <= '0;
    end else if (state == BEEP_ON && state_nx == BEEP_OFF) begin
      beep_cnt <= beep_inc;
    end else if (state == BEEP_ON && state_nx == GAP) begin
      beep_cnt <= '0;
    end
  end

  // Buzzer square wave: starts low on each beep, toggles every TONE_HALF cycles, low when silent.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      tone_cnt <= '0;
      buzzer   <= 1'b0;
    end else if (state_nx == BEEP_ON && state == BEEP_ON) begin
      if (tone_cnt >= CNT_W'(TONE_HALF - 1)) begin
        tone_cnt <= '0;
        buzzer   <= ~buzzer;
      end else begin
        tone_cnt <= tone_cnt + CNT_W'(1);
      end
    end else begin
      tone_cnt <= '0;
      buzzer   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_alert.sv
// Directed bench for timer_alert: reset, pattern, ack, auto-stop, abort, burst lengths.
module tb_timer_alert;

  localparam int unsigned T_TICK = 10;
  localparam int unsigned T_TONE = 2;
  localparam int unsigned T_ON   = 3;
  localparam int unsigned T_OFF  = 2;
  localparam int unsigned T_BEEP = 2;
  localparam int unsigned T_GAP  = 5;
  localparam int unsigned T_AUTO = 40;

  logic clk_50MHz = 1'b0;
  logic rst, signal, B_S, B_L;
  logic stopsignal, buzzer, led, ringing;
  logic signal2, bs2, bl2;
  logic stop2, buzz2, led2, ring2;

  int n_err = 0;
  int n_chk = 0;
  int stop_cnt = 0;
  int exp_b[4];

  always #5 clk_50MHz = ~clk_50MHz;

  timer_alert #(
    .TICK_DIV(T_TICK), .TONE_HALF(T_TONE), .BEEP_ON_MS(T_ON), .BEEP_OFF_MS(T_OFF),
    .BURST_BEEPS(T_BEEP), .BURST_GAP_MS(T_GAP), .AUTO_STOP_MS(T_AUTO)
  ) u_dut (
    .clk_50MHz(clk_50MHz), .rst(rst), .signal(signal), .B_S(B_S), .B_L(B_L),
    .stopsignal(stopsignal), .buzzer(buzzer), .led(led), .ringing(ringing)
  );

  // Long auto-stop so four full bursts fit before it fires.
  timer_alert #(
    .TICK_DIV(T_TICK), .TONE_HALF(T_TONE), .BEEP_ON_MS(T_ON), .BEEP_OFF_MS(T_OFF),
    .BURST_BEEPS(T_BEEP), .BURST_GAP_MS(T_GAP), .AUTO_STOP_MS(200)
  ) u_esc (
    .clk_50MHz(clk_50MHz), .rst(rst), .signal(signal2), .B_S(bs2), .B_L(bl2),
    .stopsignal(stop2), .buzzer(buzz2), .led(led2), .ringing(ring2)
  );

  // Count stopsignal-high cycles.
  always @(negedge clk_50MHz) if (stopsignal === 1'b1) stop_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic wait_ring(output int lat);
    lat = 0;
    while (ringing !== 1'b1 && lat < 20) begin
      cyc(1);
      lat++;
    end
  endtask

  // Length of the current led run at level lvl; counts buzzer samples off the expected waveform.
  task automatic run_len(input logic lvl, output int len, output int bad);
    len = 0;
    bad = 0;
    while (led === lvl && len < 300) begin
      if (lvl == 1'b0 && buzzer !== 1'b0) bad++;
      if (lvl == 1'b1 && buzzer !== 1'((len >> 1) & 1)) bad++;
      len++;
      cyc(1);
    end
  endtask

  initial begin
    int lat, len, bad, bad_tot, s0, cnt, any_ring;
    int b, beeps, low, guard;
    int got_b[4];
    logic prev;

`ifdef ALERT_ESCALATE_EN
    exp_b = '{2, 3, 4, 4};
`else
    exp_b = '{2, 2, 2, 2};
`endif

    rst = 1'b1; signal = 1'b1; B_S = 1'b0; B_L = 1'b0;
    signal2 = 1'b0; bs2 = 1'b0; bl2 = 1'b0;

    // Reset with signal high.
    cyc(3);
    check("rst_stop", 32'(stopsignal), 0);
    check("rst_buzz", 32'(buzzer), 0);
    check("rst_led", 32'(led), 0);
    check("rst_ring", 32'(ringing), 0);
    rst = 1'b0;
    any_ring = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (ringing !== 1'b0) any_ring = 1;
    end
    check("post_rst_ring", 32'(any_ring), 0);

    // Pattern: 30 on, 20 off, 30 on, 50 gap, 30 on.
    signal = 1'b0;
    cyc(3);
    signal = 1'b1;
    wait_ring(lat);
    check("ring_lat", 32'(lat), 2);
    bad_tot = 0;
    run_len(1'b1, len, bad); bad_tot += bad; check("on1_len", 32'(len), 30);
    run_len(1'b0, len, bad); bad_tot += bad; check("off1_len", 32'(len), 20);
    run_len(1'b1, len, bad); bad_tot += bad; check("on2_len", 32'(len), 30);
    run_len(1'b0, len, bad); bad_tot += bad; check("gap_len", 32'(len), 50);
    run_len(1'b1, len, bad); bad_tot += bad; check("on3_len", 32'(len), 30);
    check("buzz_shape", 32'(bad_tot), 0);

    // Abort: drop signal in mid BEEP_OFF.
    cyc(5);
    s0 = stop_cnt;
    signal = 1'b0;
    cyc(2);
    check("abort_ring", 32'(ringing), 0);
    cyc(5);
    check("abort_nostop", 32'(stop_cnt - s0), 0);

    // Ack with B_S during the second beep.
    signal = 1'b1;
    wait_ring(lat);
    check("ack_ring_lat", 32'(lat), 2);
    run_len(1'b1, len, bad);
    run_len(1'b0, len, bad);
    cyc(5);
    s0 = stop_cnt;
    B_S = 1'b1;
    cyc(1);
    B_S = 1'b0;
    check("ack_pre_led", 32'(led), 1);
    cyc(1);
    check("ack_stop", 32'(stopsignal), 1);
    check("ack_led", 32'(led), 0);
    check("ack_buzz", 32'(buzzer), 0);
    check("ack_ring", 32'(ringing), 0);
    cyc(1);
    check("ack_pulse_len", 32'(stopsignal), 0);
    signal = 1'b0;
    cyc(3);
    check("ack_idle_ring", 32'(ringing), 0);
    check("ack_once", 32'(stop_cnt - s0), 1);
    signal = 1'b1;
    wait_ring(lat);
    check("restart_lat", 32'(lat), 2);
    run_len(1'b1, len, bad);
    check("restart_on", 32'(len), 30);
    signal = 1'b0;
    cyc(4);

    // Auto-stop 400 cycles after ringing rises, then HOLD with signal high.
    signal = 1'b1;
    wait_ring(lat);
    s0 = stop_cnt;
    cnt = 0;
    while (stopsignal !== 1'b1 && cnt < 600) begin
      cyc(1);
      cnt++;
    end
    check("auto_at", 32'(cnt), 400);
    any_ring = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (ringing !== 1'b0) any_ring = 1;
    end
    check("hold_no_ring", 32'(any_ring), 0);
    check("auto_once", 32'(stop_cnt - s0), 1);
    signal = 1'b0;
    cyc(4);

    // B_L edge in the same cycle as the auto-stop hit.
    signal = 1'b1;
    wait_ring(lat);
    s0 = stop_cnt;
    cyc(398);
    B_L = 1'b1;
    cyc(2);
    check("both_at", 32'(stopsignal), 1);
    cyc(5);
    B_L = 1'b0;
    cyc(30);
    check("both_once", 32'(stop_cnt - s0), 1);
    signal = 1'b0;
    cyc(4);

    // Beeps per burst on the long-timeout instance.
    signal2 = 1'b1;
    lat = 0;
    while (ring2 !== 1'b1 && lat < 20) begin
      cyc(1);
      lat++;
    end
    check("esc_ring_lat", 32'(lat), 2);
    b = 0; beeps = 0; low = 0; guard = 0; prev = 1'b0;
    got_b = '{0, 0, 0, 0};
    while (b < 4 && guard < 3000) begin
      if (led2 === 1'b1 && prev == 1'b0) beeps++;
      if (led2 !== 1'b1) low++; else low = 0;
      if (low == 30) begin
        got_b[b] = beeps;
        beeps = 0;
        b++;
      end
      prev = (led2 === 1'b1);
      cyc(1);
      guard++;
    end
    check("bursts_seen", 32'(b), 4);
    for (int i = 0; i < 4; i++) check($sformatf("burst%0d", i), 32'(got_b[i]), 32'(exp_b[i]));
    signal2 = 1'b0;
    cyc(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
